// File: rtl/mont_reduce.sv
// Montgomery reduction out of the R = 2^len domain: mr_out = num_in * 2^-len mod N.
// Each RUN cycle performs one bit-serial halving step; FIX applies the final conditional subtract.
module mont_reduce (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mr_start,
  input  logic [7:0]  len,
  input  logic [31:0] num_in,
  input  logic [31:0] modulus,
  output logic        mr_end,
  output logic        mr_err,
  output logic [31:0] mr_out
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e      state_q, state_d;
  logic [32:0] t_q, t_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] nr_q, nr_d;
  logic [31:0] out_q, out_d;
  logic        err_q, err_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    nr_d    = nr_q;
    out_d   = out_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (mr_start) begin
          t_d   = {1'b0, num_in};
          cnt_d = len;
          nr_d  = modulus;
          if (!modulus[0]) begin
            state_d = DONE;
            err_d   = 1'b1;
            out_d   = '0;
          end else if (len == 8'd0) begin
            state_d = FIX;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Sum is widened to 34 bits so the carry out of T + N survives the shift.
        t_d   = 33'(({1'b0, t_q} + {2'b0, nr_q & {32{t_q[0]}}}) >> 1);
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = FIX;
      end
      FIX: begin
        out_d   = (t_q >= {1'b0, nr_q}) ? 32'(t_q - {1'b0, nr_q}) : t_q[31:0];
        err_d   = 1'b0;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      t_q     <= '0;
      cnt_q   <= '0;
      nr_q    <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      nr_q    <= nr_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign mr_end = (state_q == DONE);
  assign mr_err = err_q;
  assign mr_out = out_q;

endmodule

// File: tb/tb_mont_reduce.sv
// Self-checking bench for mont_reduce: directed vector table, hand-written corner sequences,
// and randomized operations checked against a modular-arithmetic reference model.
module tb_mont_reduce;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mr_start;
  logic [7:0]  len;
  logic [31:0] num_in;
  logic [31:0] modulus;
  logic        mr_end;
  logic        mr_err;
  logic [31:0] mr_out;

  int n_checks = 0;
  int n_fail   = 0;

  mont_reduce dut (
    .clk      (clk),
    .rstn     (rstn),
    .mr_start (mr_start),
    .len      (len),
    .num_in   (num_in),
    .modulus  (modulus),
    .mr_end   (mr_end),
    .mr_err   (mr_err),
    .mr_out   (mr_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] num;
    logic [31:0] n;
    logic [7:0]  l;
    logic [31:0] exp_out;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // x * 2^-l mod n via repeated multiplication by the inverse of 2 ((n+1)/2 for odd n).
  function automatic longint unsigned ref_reduce(input logic [31:0] x, input logic [31:0] n,
                                                 input int l);
    longint unsigned r, inv2;
    r    = longint'(x) % longint'(n);
    inv2 = (longint'(n) + 1) / 2;
    for (int i = 0; i < l; i++) r = (r * inv2) % longint'(n);
    return r;
  endfunction

  // Launch one operation and measure cycles from the start edge to the mr_end cycle.
  // With noisy set, inputs and mr_start are scrambled while the operation is in flight.
  task automatic run_op(input logic [31:0] num, input logic [31:0] n, input logic [7:0] l,
                        input bit noisy, output logic [31:0] out, output logic err,
                        output int lat);
    @(negedge clk);
    num_in = num; modulus = n; len = l; mr_start = 1'b1;
    @(negedge clk);
    mr_start = 1'b0;
    lat = -1;
    for (int c = 0; c < 400; c++) begin
      if (noisy) begin
        num_in = $urandom; modulus = $urandom; len = 8'($urandom);
        mr_start = 1'($urandom);
      end
      if (mr_end) begin
        mr_start = 1'b0;
        lat = c;
        break;
      end
      @(negedge clk);
    end
    out = mr_out;
    err = mr_err;
  endtask

  task automatic do_vec(input string tag, input vec_t v, input bit noisy);
    logic [31:0] out;
    logic        err;
    int          lat;
    run_op(v.num, v.n, v.l, noisy, out, err, lat);
    check({tag, " latency"}, lat, v.exp_err ? 0 : int'(v.l) + 1);
    check({tag, " mr_err"}, err, v.exp_err);
    check({tag, " mr_out"}, out, v.exp_out);
    @(negedge clk);
    check({tag, " mr_end one cycle"}, mr_end, 0);
    check({tag, " mr_out held"}, mr_out, v.exp_out);
    check({tag, " mr_err held"}, mr_err, v.exp_err);
  endtask

  task automatic count_ends(input int cycles, output int ends);
    ends = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (mr_end) ends++;
    end
  endtask

  initial begin
    vec_t        vecs[8];
    vec_t        v;
    logic [31:0] out;
    logic        err;
    int          lat, ends;
    longint unsigned lim;

    vecs[0] = '{32'd6,          32'd11,         8'd4,   32'd10,         1'b0};
    vecs[1] = '{32'd1,          32'd7,          8'd3,   32'd1,          1'b0};
    vecs[2] = '{32'd1,          32'd1,          8'd1,   32'd0,          1'b0};
    vecs[3] = '{32'd20,         32'd13,         8'd0,   32'd7,          1'b0};
    vecs[4] = '{32'd5,          32'd10,         8'd4,   32'd0,          1'b1};
    vecs[5] = '{32'd5,          32'd0,          8'd4,   32'd0,          1'b1};
    vecs[6] = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  8'd32,  32'hFFFF_FFFE,  1'b0};
    vecs[7] = '{32'd3,          32'd5,          8'd255, 32'd1,          1'b0};

    rstn = 1'b0; mr_start = 1'b0; len = '0; num_in = '0; modulus = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    check("reset mr_end", mr_end, 0);
    check("reset mr_err", mr_err, 0);
    check("reset mr_out", mr_out, 0);

    for (int i = 0; i < 8; i++) do_vec($sformatf("vec%0d", i), vecs[i], 1'b0);

    // mr_start pulsed mid-RUN with other operands: ignored, not queued.
    @(negedge clk);
    num_in = 32'd6; modulus = 32'd11; len = 8'd4; mr_start = 1'b1;
    @(negedge clk);
    mr_start = 1'b0;
    @(negedge clk);
    num_in = 32'd1; modulus = 32'd7; len = 8'd3; mr_start = 1'b1;
    @(negedge clk);
    mr_start = 1'b0;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      if (mr_end) begin lat = c + 2; break; end
      @(negedge clk);
    end
    check("restart ignored latency", lat, 5);
    check("restart ignored mr_out", mr_out, 10);
    count_ends(12, ends);
    check("restart not queued", ends, 0);

    // Reset held one cycle in the middle of RUN.
    @(negedge clk);
    num_in = 32'd12345; modulus = 32'd999_983; len = 8'd20; mr_start = 1'b1;
    @(negedge clk);
    mr_start = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("midrun reset mr_end", mr_end, 0);
    check("midrun reset mr_err", mr_err, 0);
    check("midrun reset mr_out", mr_out, 0);
    count_ends(30, ends);
    check("midrun reset aborts op", ends, 0);

    // mr_start coincident with reset is discarded.
    do_vec("pre-reset op", vecs[0], 1'b0);
    @(negedge clk);
    rstn = 1'b0; num_in = 32'd6; modulus = 32'd11; len = 8'd2; mr_start = 1'b1;
    @(negedge clk);
    rstn = 1'b1; mr_start = 1'b0;
    check("start under reset mr_out", mr_out, 0);
    count_ends(10, ends);
    check("start under reset discarded", ends, 0);

    // Randomized operations with the precondition num_in < N * 2^len enforced.
    for (int i = 0; i < 40; i++) begin
      v.n   = $urandom;
      v.n   = ($urandom_range(0, 7) == 0) ? (v.n & ~32'd1) : (v.n | 32'd1);
      v.l   = 8'($urandom_range(0, 40));
      v.num = $urandom;
      if (v.n[0] && v.l < 8'd32) begin
        lim = longint'(v.n) << v.l;
        if (longint'(v.num) >= lim) v.num = 32'(longint'(v.num) % lim);
      end
      v.exp_err = ~v.n[0];
      v.exp_out = v.n[0] ? 32'(ref_reduce(v.num, v.n, int'(v.l))) : 32'd0;
      do_vec($sformatf("rand%0d", i), v, i[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mont_reduce.md
MONT_REDUCE -- requirements
Module: mont_reduce

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset SHALL be synchronous and active-low, named rstn.
REQ-002 Ports SHALL be:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- mr_start  in  1  start pulse, sampled only in IDLE
- len  in  8  log2(R), R = 2^len
- num_in  in  32  Montgomery-domain operand
- modulus  in  32  modulus N
- mr_end  out  1  one-cycle done pulse
- mr_err  out  1  error flag, valid while mr_end=1
- mr_out  out  32  result = num_in * R^-1 mod N
REQ-003 The block SHALL be the out-of-Montgomery-domain counterpart of long_div: mont_reduce(long_div(x, len, N), len, N) = x mod N for odd N.

Function
REQ-004 States SHALL be IDLE, RUN, FIX, DONE.
REQ-005 In IDLE with mr_start=1 at edge k, the block SHALL latch len, num_in and modulus into internal registers: T (33-bit) = num_in, cnt = len, Nr = modulus.
- Inputs SHALL NOT be sampled again until the next start.
REQ-006 Transitions at edge k SHALL be:
- modulus[0]=0 (includes N=0) -> DONE with mr_err=1 and mr_out=0.
- len=0 -> FIX.
- otherwise -> RUN.
REQ-007 RUN, once per cycle:
- if T[0]=1 then T = (T + Nr) >> 1, else T = T >> 1, computed at 33-bit width with no truncation.
- cnt decrements; the edge where cnt goes 1->0 moves to FIX.
REQ-008 FIX, single cycle: mr_out = (T >= Nr) ? T - Nr : T[31:0]; mr_err = 0; go to DONE.
REQ-009 DONE SHALL hold mr_end=1 for exactly one cycle and then return to IDLE.
- mr_end SHALL be decoded from state (DONE) only.
REQ-010 Latency: for valid N, mr_end SHALL be high in the cycle after edge k+len+1. For even N, it SHALL be high in the cycle after edge k.
REQ-011 mr_out and mr_err SHALL hold their values from DONE until the next operation's FIX or error entry.
REQ-012 mr_start outside IDLE (RUN/FIX/DONE) SHALL be ignored and SHALL NOT be queued.
REQ-013 Result precondition: mr_out is the exact modular result when num_in < N*2^len.
- Otherwise mr_out SHALL equal the bit-exact output of REQ-007/REQ-008; no further correction is applied.
REQ-014 len up to 255 SHALL be supported with no cap; the iteration count equals len exactly.
REQ-015 Only one operation SHALL be in flight at a time.

Reset
REQ-016 At an edge with rstn=0:
- state = IDLE; mr_end = 0; mr_err = 0; mr_out = 0; T, cnt and Nr cleared.
- This takes priority over any state, including mid-RUN.
REQ-017 mr_start sampled in the same cycle as rstn=0 SHALL be discarded.

Verification
REQ-018 num_in=6, N=11, len=4 -> mr_out=10, mr_err=0, mr_end high in the cycle after edge k+5 (round-trip of long_div 10*16 mod 11=6).
REQ-019 num_in=1, N=7, len=3 -> mr_out=1. Also num_in=1, N=1, len=1 -> mr_out=0.
REQ-020 len=0, num_in=20, N=13 -> mr_out=7, mr_end high in the cycle after edge k+1.
REQ-021 N=10 (even) or N=0 -> mr_err=1, mr_out=0, mr_end high in the cycle after edge k.
REQ-022 num_in=0xFFFFFFFE, N=0xFFFFFFFF, len=32 -> mr_out=0xFFFFFFFE; this exercises the 33-bit carry in T+N.
REQ-023 Reset and restart:
- rstn=0 for one cycle during RUN -> next cycle IDLE, all outputs 0.
- mr_start pulsed during RUN -> ignored, and the original result is unchanged.
